// File: rtl/gpio_apb_sequencer.sv
// APB master sharing one CoreGPIO between two requesters (round-robin) and
// autonomously servicing GPIO interrupts with an IRQ read/clear-write pair.
module gpio_apb_sequencer #(
  parameter int                APB_AW   = 8,
  parameter int                APB_DW   = 32,
  parameter int                IO_NUM   = 2,
  parameter logic [APB_AW-1:0] IRQ_ADDR = 8'h80,
  parameter int                TIMEOUT  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [APB_AW-1:0] req0_addr,
  input  logic [APB_DW-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [APB_DW-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [APB_AW-1:0] req1_addr,
  input  logic [APB_DW-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [APB_DW-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [IO_NUM-1:0] INT,
  output logic              irq_evt,
  output logic [IO_NUM-1:0] irq_mask
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [1:0] {PH_NONE, PH_RD, PH_WR} phase_t;

  state_t              state_r, state_nxt;
  phase_t              phase_r, phase_nxt;
  logic                owner_r, owner_nxt;
  logic                last_grant_r, last_grant_nxt;
  logic [TW-1:0]       tmo_cnt_r, tmo_cnt_nxt;
  logic [1:0]          holdoff_r, holdoff_nxt;
  logic [IO_NUM-1:0]   cap_r, cap_nxt;
  logic                cap_err_r, cap_err_nxt;
  logic                psel_r, psel_nxt;
  logic                penable_r, penable_nxt;
  logic                pwrite_r, pwrite_nxt;
  logic [APB_AW-1:0]   paddr_r, paddr_nxt;
  logic [APB_DW-1:0]   pwdata_r, pwdata_nxt;
  logic                rsp0_valid_r, rsp0_valid_nxt;
  logic                rsp1_valid_r, rsp1_valid_nxt;
  logic [APB_DW-1:0]   rsp0_rdata_r, rsp0_rdata_nxt;
  logic [APB_DW-1:0]   rsp1_rdata_r, rsp1_rdata_nxt;
  logic                rsp0_err_r, rsp0_err_nxt;
  logic                rsp1_err_r, rsp1_err_nxt;
  logic                irq_evt_r, irq_evt_nxt;
  logic [IO_NUM-1:0]   irq_mask_r, irq_mask_nxt;

  logic                irq_sel_s;
  logic                grant_vld_s;
  logic                grant_s;
  logic                done_s;
  logic                done_err_s;
  logic [APB_DW-1:0]   done_rdata_s;
  logic [APB_DW-1:0]   rsp_rdata_s;

  // Arbitration: pending IRQ beats requesters; contention goes to the one not last granted
  always_comb begin
    irq_sel_s = (|INT) && (holdoff_r == 2'd0);
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = ~last_grant_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
    end
  end

  assign req0_ready = (state_r == ST_IDLE) && !irq_sel_s && grant_vld_s && !grant_s;
  assign req1_ready = (state_r == ST_IDLE) && !irq_sel_s && grant_vld_s && grant_s;

  // Transfer completion: a timeout reports an error with zero read data
  always_comb begin
    done_s       = PREADY || (tmo_cnt_r == TMO_LAST);
    done_err_s   = PREADY ? PSLVERR : 1'b1;
    done_rdata_s = PREADY ? PRDATA : {APB_DW{1'b0}};
    rsp_rdata_s  = (pwrite_r || done_err_s) ? {APB_DW{1'b0}} : done_rdata_s;
  end

  // Next-state and next-output logic for the APB sequencer
  always_comb begin
    state_nxt      = state_r;
    phase_nxt      = phase_r;
    owner_nxt      = owner_r;
    last_grant_nxt = last_grant_r;
    tmo_cnt_nxt    = tmo_cnt_r;
    holdoff_nxt    = (holdoff_r != 2'd0) ? (holdoff_r - 2'd1) : 2'd0;
    cap_nxt        = cap_r;
    cap_err_nxt    = cap_err_r;
    psel_nxt       = psel_r;
    penable_nxt    = penable_r;
    pwrite_nxt     = pwrite_r;
    paddr_nxt      = paddr_r;
    pwdata_nxt     = pwdata_r;
    rsp0_valid_nxt = 1'b0;
    rsp1_valid_nxt = 1'b0;
    rsp0_rdata_nxt = {APB_DW{1'b0}};
    rsp1_rdata_nxt = {APB_DW{1'b0}};
    rsp0_err_nxt   = 1'b0;
    rsp1_err_nxt   = 1'b0;
    irq_evt_nxt    = 1'b0;
    irq_mask_nxt   = {IO_NUM{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (irq_sel_s) begin
          state_nxt  = ST_SETUP;
          phase_nxt  = PH_RD;
          psel_nxt   = 1'b1;
          pwrite_nxt = 1'b0;
          paddr_nxt  = IRQ_ADDR;
          pwdata_nxt = {APB_DW{1'b0}};
        end else if (grant_vld_s) begin
          state_nxt      = ST_SETUP;
          phase_nxt      = PH_NONE;
          owner_nxt      = grant_s;
          last_grant_nxt = grant_s;
          psel_nxt       = 1'b1;
          pwrite_nxt     = grant_s ? req1_write : req0_write;
          paddr_nxt      = grant_s ? req1_addr  : req0_addr;
          pwdata_nxt     = grant_s ? req1_wdata : req0_wdata;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
        tmo_cnt_nxt = {TW{1'b0}};
      end
      ST_ACCESS: begin
        if (done_s) begin
          state_nxt   = ST_RESP;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          tmo_cnt_nxt = {TW{1'b0}};
          cap_nxt     = done_rdata_s[IO_NUM-1:0];
          cap_err_nxt = done_err_s;
          case (phase_r)
            PH_NONE: begin
              rsp0_valid_nxt = !owner_r;
              rsp1_valid_nxt = owner_r;
              rsp0_rdata_nxt = owner_r ? {APB_DW{1'b0}} : rsp_rdata_s;
              rsp1_rdata_nxt = owner_r ? rsp_rdata_s : {APB_DW{1'b0}};
              rsp0_err_nxt   = !owner_r && done_err_s;
              rsp1_err_nxt   = owner_r && done_err_s;
            end
            PH_WR: begin
              irq_evt_nxt  = 1'b1;
              irq_mask_nxt = pwdata_r[IO_NUM-1:0];
            end
            default: begin
              irq_evt_nxt = 1'b0;
            end
          endcase
        end else begin
          tmo_cnt_nxt = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        case (phase_r)
          PH_RD: begin
            // Only a clean read with pending bits leads to the clear write
            if (cap_err_r || (cap_r == {IO_NUM{1'b0}})) begin
              state_nxt = ST_IDLE;
              phase_nxt = PH_NONE;
            end else begin
              state_nxt  = ST_SETUP;
              phase_nxt  = PH_WR;
              psel_nxt   = 1'b1;
              pwrite_nxt = 1'b1;
              paddr_nxt  = IRQ_ADDR;
              pwdata_nxt = {{(APB_DW-IO_NUM){1'b0}}, cap_r};
            end
          end
          PH_WR: begin
            state_nxt   = ST_IDLE;
            phase_nxt   = PH_NONE;
            holdoff_nxt = 2'd2;
          end
          default: begin
            state_nxt = ST_IDLE;
            phase_nxt = PH_NONE;
          end
        endcase
      end
      default: begin
        state_nxt   = ST_IDLE;
        phase_nxt   = PH_NONE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus and drops any in-flight transfer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r      <= ST_IDLE;
      phase_r      <= PH_NONE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      tmo_cnt_r    <= {TW{1'b0}};
      holdoff_r    <= 2'd0;
      cap_r        <= {IO_NUM{1'b0}};
      cap_err_r    <= 1'b0;
      psel_r       <= 1'b0;
      penable_r    <= 1'b0;
      pwrite_r     <= 1'b0;
      paddr_r      <= {APB_AW{1'b0}};
      pwdata_r     <= {APB_DW{1'b0}};
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {APB_DW{1'b0}};
      rsp1_rdata_r <= {APB_DW{1'b0}};
      rsp0_err_r   <= 1'b0;
      rsp1_err_r   <= 1'b0;
      irq_evt_r    <= 1'b0;
      irq_mask_r   <= {IO_NUM{1'b0}};
    end else begin
      state_r      <= state_nxt;
      phase_r      <= phase_nxt;
      owner_r      <= owner_nxt;
      last_grant_r <= last_grant_nxt;
      tmo_cnt_r    <= tmo_cnt_nxt;
      holdoff_r    <= holdoff_nxt;
      cap_r        <= cap_nxt;
      cap_err_r    <= cap_err_nxt;
      psel_r       <= psel_nxt;
      penable_r    <= penable_nxt;
      pwrite_r     <= pwrite_nxt;
      paddr_r      <= paddr_nxt;
      pwdata_r     <= pwdata_nxt;
      rsp0_valid_r <= rsp0_valid_nxt;
      rsp1_valid_r <= rsp1_valid_nxt;
      rsp0_rdata_r <= rsp0_rdata_nxt;
      rsp1_rdata_r <= rsp1_rdata_nxt;
      rsp0_err_r   <= rsp0_err_nxt;
      rsp1_err_r   <= rsp1_err_nxt;
      irq_evt_r    <= irq_evt_nxt;
      irq_mask_r   <= irq_mask_nxt;
    end
  end

  assign PSEL       = psel_r;
  assign PENABLE    = penable_r;
  assign PWRITE     = pwrite_r;
  assign PADDR      = paddr_r;
  assign PWDATA     = pwdata_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_rdata = rsp0_rdata_r;
  assign rsp1_rdata = rsp1_rdata_r;
  assign rsp0_err   = rsp0_err_r;
  assign rsp1_err   = rsp1_err_r;
  assign irq_evt    = irq_evt_r;
  assign irq_mask   = irq_mask_r;

endmodule
